// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: configuration owner, frame-activity tracker and byte FIFO
// wrapped around a UART receiver.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  IDLE    | line idle, config may be accepted, waiting for a start bit
//  BUSY    | frame in progress, counting cycles for glitch/timeout checks
//  RECOVER | frame timed out, waiting for the line to return high
module uart_rx_ctrl #(
   parameter int PRESCALE_WIDTH = 6,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic [PRESCALE_WIDTH-1:0] cfg_prescale,
   input  logic                      cfg_par_en,
   input  logic                      cfg_par_typ,
   input  logic                      RX_IN,
   output logic [PRESCALE_WIDTH-1:0] Prescale,
   output logic                      PAR_EN,
   output logic                      PAR_TYP,
   input  logic [7:0]                P_DATA,
   input  logic                      data_valid,
   output logic [7:0]                rd_data,
   output logic                      rd_valid,
   input  logic                      rd_ready,
   output logic                      overflow,
   output logic [7:0]                frame_err_cnt,
   input  logic                      clr_status
);

   localparam int CW = PRESCALE_WIDTH + 4;
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, BUSY, RECOVER} state_t;

   state_t                    state_q, state_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
   logic                      par_en_q, par_en_d;
   logic                      par_typ_q, par_typ_d;
   logic [7:0]                mem_q [FIFO_DEPTH];
   logic [7:0]                mem_d [FIFO_DEPTH];
   logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
   logic [AW:0]               count_q, count_d;
   logic [7:0]                rd_data_q, rd_data_d;
   logic                      overflow_q, overflow_d;
   logic [7:0]                err_q, err_d;

   logic [CW-1:0]             frame_len;
   logic [CW-1:0]             half_bit;
   logic                      timeout_evt;
   logic                      push_ok, pop_ok, full;
   logic [AW:0]               remain;
   logic [AW-1:0]             head_ptr;

   // Frame length and glitch window derived from the live configuration.
   always_comb begin
      frame_len   = CW'(prescale_q) * (par_en_q ? CW'(12) : CW'(11));
      half_bit    = CW'(prescale_q >> 1);
      timeout_evt = (state_q == BUSY) && !data_valid
                    && !(RX_IN && (cnt_q < half_bit))
                    && (cnt_q == frame_len - CW'(1));
   end

   // Line-activity FSM; config is only taken when idle with the line high.
   always_comb begin
      state_d    = state_q;
      cnt_d      = '0;
      prescale_d = prescale_q;
      par_en_d   = par_en_q;
      par_typ_d  = par_typ_q;
      cfg_ready  = (state_q == IDLE) && RX_IN;
      case (state_q)
         IDLE: begin
            if (cfg_valid && cfg_ready) begin
               prescale_d = (cfg_prescale < PRESCALE_WIDTH'(4)) ?
                            PRESCALE_WIDTH'(4) : cfg_prescale;
               par_en_d   = cfg_par_en;
               par_typ_d  = cfg_par_typ;
            end
            if (!RX_IN) state_d = BUSY;
         end
         BUSY: begin
            cnt_d = cnt_q + CW'(1);
            if (data_valid)                      state_d = IDLE;
            else if (RX_IN && (cnt_q < half_bit)) state_d = IDLE;
            else if (timeout_evt)                 state_d = RECOVER;
         end
         RECOVER: begin
            if (RX_IN) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FIFO bookkeeping; rd_data is registered so it can hold while empty.
   always_comb begin
      full     = (count_q == (AW+1)'(FIFO_DEPTH));
      pop_ok   = rd_ready && (count_q != '0);
      push_ok  = data_valid && (!full || pop_ok);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = P_DATA;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d   = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      remain    = count_q - (AW+1)'(pop_ok);
      head_ptr  = rd_ptr_q + AW'(pop_ok);
      rd_data_d = rd_data_q;
      if (count_d != '0) rd_data_d = (remain == '0) ? P_DATA : mem_q[head_ptr];
   end

   // Sticky status; a clear is applied before a same-cycle event.
   always_comb begin
      overflow_d = clr_status ? 1'b0 : overflow_q;
      if (data_valid && !push_ok) overflow_d = 1'b1;
      err_d = clr_status ? 8'd0 : err_q;
      if (timeout_evt && (err_d != 8'hFF)) err_d = err_d + 8'd1;
   end

   // State registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         prescale_q <= PRESCALE_WIDTH'(8);
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'd0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_data_q  <= 8'd0;
         overflow_q <= 1'b0;
         err_q      <= 8'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         prescale_q <= prescale_d;
         par_en_q   <= par_en_d;
         par_typ_q  <= par_typ_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         overflow_q <= overflow_d;
         err_q      <= err_d;
      end
   end

   assign Prescale      = prescale_q;
   assign PAR_EN        = par_en_q;
   assign PAR_TYP       = par_typ_q;
   assign rd_data       = rd_data_q;
   assign rd_valid      = (count_q != '0);
   assign overflow      = overflow_q;
   assign frame_err_cnt = err_q;

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Control and buffering stage wrapped around the UART receiver. It owns the receiver's configuration (prescale, parity enable, parity type) and changes it only between frames, using a valid/ready handshake. It tracks frame activity on the serial line and detects start glitches and frames that never complete. Received bytes are queued in a first-word-fall-through FIFO for the downstream consumer.

## Interface
Parameters:
- PRESCALE_WIDTH, 6: width of the prescale field.
- FIFO_DEPTH, 4: byte FIFO depth; must be a power of 2, minimum 2.

Ports:
- CLK  in  1  single clock, rising-edge.
- RST  in  1  synchronous, active-high reset.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration can be accepted this cycle.
- cfg_prescale  in  PRESCALE_WIDTH  requested oversampling ratio.
- cfg_par_en  in  1  requested parity enable.
- cfg_par_typ  in  1  requested parity type (0 even, 1 odd).
- RX_IN  in  1  serial line; the same net that feeds the receiver.
- Prescale  out  PRESCALE_WIDTH  to receiver.
- PAR_EN  out  1  to receiver.
- PAR_TYP  out  1  to receiver.
- P_DATA  in  8  received byte from receiver.
- data_valid  in  1  receiver byte strobe; one cycle per good frame.
- rd_data  out  8  FIFO head byte.
- rd_valid  out  1  FIFO not empty.
- rd_ready  in  1  consumer pop.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- frame_err_cnt  out  8  saturating count of incomplete frames.
- clr_status  in  1  clears overflow and frame_err_cnt.

## Operation
- All state updates on the rising edge of CLK; no asynchronous paths.
- Reset values:
  - Prescale=8, PAR_EN=0, PAR_TYP=0.
  - rd_valid=0, rd_data=0, overflow=0, frame_err_cnt=0.
  - FIFO empty, state IDLE, counter 0.
- The FSM has three states: IDLE, BUSY and RECOVER.
- IDLE:
  - cfg_ready = (state==IDLE) && RX_IN==1. It is combinational from state and RX_IN.
  - A transfer (cfg_valid && cfg_ready) loads Prescale, PAR_EN and PAR_TYP at that edge.
  - A cfg_prescale value below 4 is stored as 4.
  - RX_IN==0 → BUSY, counter cleared to 0. Because of the cfg_ready rule, a config transfer and a start can never coincide.
- BUSY: the counter (PRESCALE_WIDTH+4 bits) increments every cycle. Priority order:
  1. data_valid=1 → push P_DATA, go to IDLE.
  2. RX_IN==1 and counter < Prescale/2 (integer shift) → start glitch; go to IDLE with no count and no push.
  3. counter == Prescale*(11+PAR_EN)-1 → timeout; frame_err_cnt += 1 (saturates at 255); go to RECOVER.
- RECOVER: wait for RX_IN==1, then go to IDLE. data_valid in RECOVER still pushes.
- data_valid seen in IDLE still pushes. This tolerates receiver/controller skew and is not an error.
- FIFO push and pop rules:
  - Push with FIFO not full: byte stored.
  - Push when full with no pop: byte dropped, overflow set.
  - Push and pop in the same cycle when full: both succeed, no overflow.
  - Pop when empty: ignored.
  - rd_data holds its last value while the FIFO is empty.
- clr_status: applied first at the edge. A same-cycle overflow or timeout event then applies, giving overflow=1 or frame_err_cnt=1.
- Reset in any state: returns to IDLE, flushes the FIFO, and restores the default configuration. A partially received frame is neither counted nor pushed.

## Timing
- Config transfer at edge N: the new Prescale/PAR_EN/PAR_TYP are visible after edge N.
- Push latency:
  - data_valid sampled at edge N with FIFO empty → rd_valid=1 and rd_data=P_DATA after edge N (one cycle).
  - Pop at edge N → the next entry (or rd_valid=0) is visible after edge N.
- Timeout is measured from the edge that entered BUSY. For Prescale=8 with PAR_EN=1 it fires at counter==95, the 96th BUSY cycle.
- Glitch window: RX_IN high while counter is 0..Prescale/2-1.
- The counter width (PRESCALE_WIDTH+4) covers 12×(2^PRESCALE_WIDTH-1) without wrap.

## Test plan
- Reset, then configure prescale=8, parity=1, even; send 0xC1, 0xFC, 0xAA back-to-back with rd_ready=1 → three pops in that order, frame_err_cnt=0, overflow=0.
- Hold rd_ready=0 and send five frames with FIFO_DEPTH=4 → rd_valid=1, overflow=1 after the fifth, the first four bytes pop in order. Then pulse clr_status → overflow=0.
- Pull RX_IN low for 1 cycle with Prescale=32 → returns to IDLE within 2 cycles, frame_err_cnt unchanged, cfg_ready=1.
- Hold RX_IN low for 100 cycles with Prescale=8, no data_valid → frame_err_cnt=1 at BUSY cycle 88 (PAR_EN=0). cfg_ready stays 0 until RX_IN rises.
- Assert cfg_valid with prescale=16 during a frame → no transfer until the frame ends and RX_IN==1, then Prescale=16 on the next edge. cfg_prescale=2 → stored as 4.
- Force 256 timeouts → frame_err_cnt saturates at 255. clr_status coincident with a timeout → frame_err_cnt=1. RST mid-frame → all outputs return to their reset values.
